// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage.
//   memState_e   : 2-bit data-memory port FSM encoding, shared with other
//                  stages so waveforms decode the same way everywhere.
//   wbEntry_t    : contents of the MEM/WB pipeline register.
//   WB_BUBBLE    : an all-zero WB entry (no register-file write).
//   wordAlign()  : clears the byte-offset bits of an address.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    MEM_STATE_IDLE = 2'd0,
    MEM_STATE_BUSY = 2'd1,
    MEM_STATE_DONE = 2'd2
  } memState_e;

  typedef struct packed {
    logic        shouldWrite;
    logic [4:0]  addr;
    logic [31:0] data;
  } wbEntry_t;

  localparam wbEntry_t WB_BUBBLE = '{shouldWrite: 1'b0, addr: 5'd0, data: 32'd0};

  // Only whole-word accesses exist, so the low two address bits are
  // simply dropped rather than faulting on a misaligned address.
  function automatic logic [31:0] wordAlign(input logic [31:0] byteAddr);
    return {byteAddr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory_port.sv
// Data-memory port: owns the IDLE/BUSY/DONE access FSM, the registered
// request/address/data outputs and the upstream stall.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   memOp             : EX holds a valid load or store
//   isStore           : the memory op is a store
//   byteAddress       : ALU result used as the access address
//   storeData         : data to write for a store
//   mem_ready         : memory completes the access this cycle
//   mem_request, mem_writeEnable, mem_address, mem_writeData : port registers
//   memStall          : upstream stages must hold
//   portIdle          : FSM is in IDLE (EX instruction may retire as ALU op)
//   accessComplete    : outstanding access finishes on this edge
module data_memory_port
  import mem_wb_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        memOp,
  input  logic        isStore,
  input  logic [31:0] byteAddress,
  input  logic [31:0] storeData,
  input  logic        mem_ready,
  output logic        mem_request,
  output logic        mem_writeEnable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        memStall,
  output logic        portIdle,
  output logic        accessComplete
);

  memState_e   state_q, state_d;
  logic        request_q, request_d;
  logic        writeEnable_q, writeEnable_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writeData_q, writeData_d;

  // mem_ready only counts while a request is actually outstanding, so a
  // stray ready after an abandoned (reset) access has no effect.
  assign accessComplete = (state_q == MEM_STATE_BUSY) && request_q && mem_ready;

  // Next-state logic: latch the port in IDLE, hold it in BUSY until the
  // memory answers, then spend one DONE cycle while EX drops the
  // already-completed instruction so it is not reissued.
  always_comb begin
    state_d       = state_q;
    request_d     = request_q;
    writeEnable_d = writeEnable_q;
    address_d     = address_q;
    writeData_d   = writeData_q;
    case (state_q)
      MEM_STATE_IDLE: begin
        if (memOp) begin
          request_d     = 1'b1;
          writeEnable_d = isStore;
          address_d     = wordAlign(byteAddress);
          writeData_d   = storeData;
          state_d       = MEM_STATE_BUSY;
        end
      end
      MEM_STATE_BUSY: begin
        if (accessComplete) begin
          request_d = 1'b0;
          state_d   = MEM_STATE_DONE;
        end
      end
      MEM_STATE_DONE: begin
        state_d = MEM_STATE_IDLE;
      end
      default: begin
        request_d = 1'b0;
        state_d   = MEM_STATE_IDLE;
      end
    endcase
  end

  // State and port registers; reset abandons any outstanding access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= MEM_STATE_IDLE;
      request_q     <= 1'b0;
      writeEnable_q <= 1'b0;
      address_q     <= 32'd0;
      writeData_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      request_q     <= request_d;
      writeEnable_q <= writeEnable_d;
      address_q     <= address_d;
      writeData_q   <= writeData_d;
    end
  end

  // Stall depends only on state and EX inputs, never on mem_ready, so
  // there is no combinational path from the memory into the pipeline.
  assign memStall        = ((state_q == MEM_STATE_IDLE) && memOp) || (state_q == MEM_STATE_BUSY);
  assign portIdle        = (state_q == MEM_STATE_IDLE);
  assign mem_request     = request_q;
  assign mem_writeEnable = writeEnable_q;
  assign mem_address     = address_q;
  assign mem_writeData   = writeData_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage of the five-stage MIPS pipeline. Runs word loads/stores
// over a request/ready data-memory handshake, stalls upstream while an
// access is outstanding, and holds the MEM/WB register that drives the
// register-file write port.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   ex_*         : EX-stage results and control
//   mem_*        : data-memory request/ready interface
//   memStall     : upstream stages (IF/ID/EX) must hold
//   wb_*         : register-file write enable/address/data
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_aluOutput,
  input  logic [31:0] ex_registerRt,
  input  logic        ex_shouldWriteRegister,
  input  logic        ex_shouldWriteMemoryElseAluOutputToRegister,
  input  logic        ex_shouldWriteMemory,
  input  logic [4:0]  ex_registerWriteAddress,
  output logic        mem_request,
  output logic        mem_writeEnable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  input  logic        mem_ready,
  input  logic [31:0] mem_readData,
  output logic        memStall,
  output logic        wb_shouldWriteRegister,
  output logic [4:0]  wb_registerWriteAddress,
  output logic [31:0] wb_registerWriteData
);

  logic     memOp;
  logic     portIdle;
  logic     accessComplete;
  wbEntry_t wb_q, wb_d;

  assign memOp = ex_valid & (ex_shouldWriteMemoryElseAluOutputToRegister | ex_shouldWriteMemory);

  data_memory_port u_port (
    .clock           (clock),
    .reset           (reset),
    .memOp           (memOp),
    .isStore         (ex_shouldWriteMemory),
    .byteAddress     (ex_aluOutput),
    .storeData       (ex_registerRt),
    .mem_ready       (mem_ready),
    .mem_request     (mem_request),
    .mem_writeEnable (mem_writeEnable),
    .mem_address     (mem_address),
    .mem_writeData   (mem_writeData),
    .memStall        (memStall),
    .portIdle        (portIdle),
    .accessComplete  (accessComplete)
  );

  // Writeback mux: ALU results retire straight from IDLE, load data retires
  // on the completing edge, and every other cycle loads a bubble so each
  // result is written exactly once. Writes to $zero are never enabled.
  always_comb begin
    wb_d = WB_BUBBLE;
    if (portIdle && !memOp) begin
      wb_d.shouldWrite = ex_shouldWriteRegister & ex_valid;
      wb_d.addr        = ex_registerWriteAddress;
      wb_d.data        = ex_aluOutput;
    end else if (accessComplete && !mem_writeEnable) begin
      wb_d.shouldWrite = ex_shouldWriteRegister;
      wb_d.addr        = ex_registerWriteAddress;
      wb_d.data        = mem_readData;
    end
    if (wb_d.addr == 5'd0) begin
      wb_d.shouldWrite = 1'b0;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q <= WB_BUBBLE;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wb_shouldWriteRegister  = wb_q.shouldWrite;
  assign wb_registerWriteAddress = wb_q.addr;
  assign wb_registerWriteData    = wb_q.data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a table of single-cycle ALU vectors
// plus hand-written load/store/back-to-back/reset sequences.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_aluOutput;
  logic [31:0] ex_registerRt;
  logic        ex_shouldWriteRegister;
  logic        ex_shouldWriteMemoryElseAluOutputToRegister;
  logic        ex_shouldWriteMemory;
  logic [4:0]  ex_registerWriteAddress;
  logic        mem_request;
  logic        mem_writeEnable;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_ready;
  logic [31:0] mem_readData;
  logic        memStall;
  logic        wb_shouldWriteRegister;
  logic [4:0]  wb_registerWriteAddress;
  logic [31:0] wb_registerWriteData;

  int testsRun    = 0;
  int testsFailed = 0;

  mem_wb_stage dut (
    .clock                                       (clock),
    .reset                                       (reset),
    .ex_valid                                    (ex_valid),
    .ex_aluOutput                                (ex_aluOutput),
    .ex_registerRt                               (ex_registerRt),
    .ex_shouldWriteRegister                      (ex_shouldWriteRegister),
    .ex_shouldWriteMemoryElseAluOutputToRegister (ex_shouldWriteMemoryElseAluOutputToRegister),
    .ex_shouldWriteMemory                        (ex_shouldWriteMemory),
    .ex_registerWriteAddress                     (ex_registerWriteAddress),
    .mem_request                                 (mem_request),
    .mem_writeEnable                             (mem_writeEnable),
    .mem_address                                 (mem_address),
    .mem_writeData                               (mem_writeData),
    .mem_ready                                   (mem_ready),
    .mem_readData                                (mem_readData),
    .memStall                                    (memStall),
    .wb_shouldWriteRegister                      (wb_shouldWriteRegister),
    .wb_registerWriteAddress                     (wb_registerWriteAddress),
    .wb_registerWriteData                        (wb_registerWriteData)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic        regWrite;
    logic        isLoad;
    logic [4:0]  dest;
    logic        expWrite;
    logic [4:0]  expAddr;
    logic [31:0] expData;
    logic        expStall;
  } aluVec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] alu, input logic [31:0] rt,
                               input logic regWrite, input logic isLoad, input logic isStore,
                               input logic [4:0] dest);
    ex_valid                                    = valid;
    ex_aluOutput                                = alu;
    ex_registerRt                               = rt;
    ex_shouldWriteRegister                      = regWrite;
    ex_shouldWriteMemoryElseAluOutputToRegister = isLoad;
    ex_shouldWriteMemory                        = isStore;
    ex_registerWriteAddress                     = dest;
  endtask

  // Plays the memory for one load/store already presented on EX: asserts
  // mem_ready in the latency-th cycle of the request, and returns one cycle
  // after the DONE cycle (request seen low again) with statistics.
  task automatic runMemOp(input int latency, input logic [31:0] rdata,
                          output int stallCnt, output int writeCnt, output int reqRises,
                          output logic [31:0] lastData, output logic [4:0] lastAddr,
                          output logic [31:0] reqAddr, output logic reqWe,
                          output logic [31:0] reqData);
    int   reqCyc   = 0;
    bit   sawReq   = 0;
    bit   finished = 0;
    stallCnt = 0; writeCnt = 0; reqRises = 0;
    lastData = '0; lastAddr = '0; reqAddr = '0; reqWe = 1'b0; reqData = '0;
    #1;
    for (int c = 0; c < 40 && !finished; c++) begin
      if (memStall) stallCnt++;
      if (wb_shouldWriteRegister) begin
        writeCnt++;
        lastData = wb_registerWriteData;
        lastAddr = wb_registerWriteAddress;
      end
      if (mem_request) begin
        if (!sawReq) begin
          reqRises++;
          reqAddr = mem_address;
          reqWe   = mem_writeEnable;
          reqData = mem_writeData;
        end
        sawReq = 1;
        reqCyc++;
        mem_ready    = (reqCyc == latency);
        mem_readData = mem_ready ? rdata : 32'h0;
      end else begin
        mem_ready    = 1'b0;
        mem_readData = 32'h0;
        if (sawReq) finished = 1;
      end
      @(posedge clock); #1;
    end
    mem_ready = 1'b0;
    if (!finished) checkOutput("memop_timeout", 32'd1, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    aluVec_t     vecs[5];
    int          stallCnt, writeCnt, reqRises, totalRises;
    logic [31:0] lastData, reqAddr, reqData;
    logic [4:0]  lastAddr;
    logic        reqWe;

    // valid alu regWrite isLoad dest | expWrite expAddr expData expStall
    vecs[0] = '{1'b1, 32'h0000_1234, 1'b1, 1'b0, 5'd5,  1'b1, 5'd5,  32'h0000_1234, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0000_FFFF, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0042, 1'b1, 1'b0, 5'd9,  1'b0, 5'd9,  32'h0000_0042, 1'b0};
    vecs[3] = '{1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 5'd31, 1'b1, 5'd31, 32'hA5A5_A5A5, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0100, 1'b1, 1'b1, 5'd3,  1'b0, 5'd3,  32'h0000_0100, 1'b0};

    mem_ready    = 1'b0;
    mem_readData = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_request", {31'd0, mem_request}, 32'd0);
    checkOutput("reset_writeEnable", {31'd0, mem_writeEnable}, 32'd0);
    checkOutput("reset_address", mem_address, 32'd0);
    checkOutput("reset_writeData", mem_writeData, 32'd0);
    checkOutput("reset_wbWrite", {31'd0, wb_shouldWriteRegister}, 32'd0);
    checkOutput("reset_wbData", wb_registerWriteData, 32'd0);
    reset = 1'b0;

    // Single-cycle ALU vectors, including $zero and bubble cases.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].alu, 32'h0, vecs[i].regWrite, vecs[i].isLoad, 1'b0, vecs[i].dest);
      #1;
      checkOutput($sformatf("alu%0d_stall", i), {31'd0, memStall}, {31'd0, vecs[i].expStall});
      @(posedge clock); #1;
      checkOutput($sformatf("alu%0d_wbWrite", i), {31'd0, wb_shouldWriteRegister}, {31'd0, vecs[i].expWrite});
      checkOutput($sformatf("alu%0d_wbAddr", i), {27'd0, wb_registerWriteAddress}, {27'd0, vecs[i].expAddr});
      checkOutput($sformatf("alu%0d_wbData", i), wb_registerWriteData, vecs[i].expData);
      checkOutput($sformatf("alu%0d_request", i), {31'd0, mem_request}, 32'd0);
    end

    // Load from a misaligned address with ready in the 3rd request cycle.
    applyStimulus(1'b1, 32'h0000_0103, 32'h0, 1'b1, 1'b1, 1'b0, 5'd8);
    runMemOp(3, 32'hDEAD_BEEF, stallCnt, writeCnt, reqRises, lastData, lastAddr, reqAddr, reqWe, reqData);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("load_address", reqAddr, 32'h0000_0100);
    checkOutput("load_writeEnable", {31'd0, reqWe}, 32'd0);
    checkOutput("load_stallCycles", stallCnt, 32'd4);
    checkOutput("load_writeCount", writeCnt, 32'd1);
    checkOutput("load_wbData", lastData, 32'hDEAD_BEEF);
    checkOutput("load_wbAddr", {27'd0, lastAddr}, 32'd8);
    checkOutput("load_noRepeatWrite", {31'd0, wb_shouldWriteRegister}, 32'd0);

    // Store with ready in the first request cycle: minimum two-cycle stall.
    applyStimulus(1'b1, 32'h0000_0020, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1, 5'd0);
    runMemOp(1, 32'h1111_1111, stallCnt, writeCnt, reqRises, lastData, lastAddr, reqAddr, reqWe, reqData);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("store_writeEnable", {31'd0, reqWe}, 32'd1);
    checkOutput("store_writeData", reqData, 32'hCAFE_0001);
    checkOutput("store_address", reqAddr, 32'h0000_0020);
    checkOutput("store_stallCycles", stallCnt, 32'd2);
    checkOutput("store_writeCount", writeCnt, 32'd0);

    // Back-to-back loads; the second enters EX right after the DONE cycle.
    applyStimulus(1'b1, 32'h0000_0040, 32'h0, 1'b1, 1'b1, 1'b0, 5'd10);
    runMemOp(1, 32'h1357_9BDF, stallCnt, writeCnt, reqRises, lastData, lastAddr, reqAddr, reqWe, reqData);
    totalRises = reqRises;
    checkOutput("b2b_first_data", lastData, 32'h1357_9BDF);
    checkOutput("b2b_first_addr", {27'd0, lastAddr}, 32'd10);
    checkOutput("b2b_first_writes", writeCnt, 32'd1);
    applyStimulus(1'b1, 32'h0000_0044, 32'h0, 1'b1, 1'b1, 1'b0, 5'd11);
    runMemOp(1, 32'h2468_ACE0, stallCnt, writeCnt, reqRises, lastData, lastAddr, reqAddr, reqWe, reqData);
    totalRises += reqRises;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("b2b_second_reqAddr", reqAddr, 32'h0000_0044);
    checkOutput("b2b_second_data", lastData, 32'h2468_ACE0);
    checkOutput("b2b_second_addr", {27'd0, lastAddr}, 32'd11);
    checkOutput("b2b_second_writes", writeCnt, 32'd1);
    checkOutput("b2b_requests", totalRises, 32'd2);

    // Reset while BUSY, then a stray mem_ready pulse.
    applyStimulus(1'b1, 32'h0000_0080, 32'h0, 1'b1, 1'b1, 1'b0, 5'd12);
    @(posedge clock); #1;
    checkOutput("rst_busy_request", {31'd0, mem_request}, 32'd1);
    checkOutput("rst_busy_address", mem_address, 32'h0000_0080);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("rst_request", {31'd0, mem_request}, 32'd0);
    checkOutput("rst_address", mem_address, 32'd0);
    checkOutput("rst_stall", {31'd0, memStall}, 32'd0);
    checkOutput("rst_wbWrite", {31'd0, wb_shouldWriteRegister}, 32'd0);
    mem_ready    = 1'b1;
    mem_readData = 32'h5555_5555;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd12);
    @(posedge clock); #1;
    mem_ready    = 1'b0;
    mem_readData = 32'h0;
    checkOutput("stray_ready_wbWrite", {31'd0, wb_shouldWriteRegister}, 32'd0);
    checkOutput("stray_ready_request", {31'd0, mem_request}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0077, 32'h0, 1'b1, 1'b0, 1'b0, 5'd7);
    #1;
    checkOutput("post_rst_stall", {31'd0, memStall}, 32'd0);
    @(posedge clock); #1;
    checkOutput("post_rst_wbWrite", {31'd0, wb_shouldWriteRegister}, 32'd1);
    checkOutput("post_rst_wbData", wb_registerWriteData, 32'h0000_0077);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
